seg7_scan: RTL and testbench



---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_hex_dec.sv | 11 +
 rtl/seg7_scan.sv | 76 +++++++
 tb/tb_seg7_scan.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the 8-digit 7-segment scanner.
package seg7_pkg;

  localparam int SEG7_DIGITS = 8;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_OFF = 7'h7F;

  // Active-low glyphs, bit 0 = a ... bit 6 = g
  localparam seg7_t SEG7_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational nibble to active-low 7-segment glyph decoder.
import seg7_pkg::*;

module seg7_hex_dec (
  input  logic [3:0] nib,
  output seg7_t      seg
);

  assign seg = SEG7_GLYPH[nib];

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed 7-segment driver with per-frame shadow load.
// Define SEG7_LZ_BLANK_EN to blank leading-zero digits.
import seg7_pkg::*;

module seg7_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   shadow;
  logic          slot_end;
  logic          frame_end;
  logic [31:0]   upper;
  logic          lz;
  logic          dark;
  seg7_t         glyph;

  assign slot_end  = cnt == CW'(REFRESH_DIV - 1);
  assign frame_end = slot_end && (idx == 3'd7);
  assign upper     = shadow >> {idx, 2'b00};

`ifdef SEG7_LZ_BLANK_EN
  assign lz = (idx != 3'd0) && (upper == 32'd0);
`else
  assign lz = 1'b0;
`endif

  assign dark = (cnt < CW'(BLANK_CYC)) || lz;

  seg7_hex_dec u_dec (
    .nib (upper[3:0]),
    .seg (glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      frame_done <= frame_end;
      // idx wraps 7 -> 0 exactly when the shadow reloads
      if (slot_end)
        idx <= idx + 3'd1;
      if (frame_end)
        shadow <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 8'hFF;
      seg <= SEG7_OFF;
    end else if (dark) begin
      an  <= 8'hFF;
      seg <= SEG7_OFF;
    end else begin
      an  <= ~(8'd1 << idx);
      seg <= glyph;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: cycle model plus directed digit checks.
module tb_seg7_scan;

  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int n_run;
  int n_fail;
  int ecnt;

  logic [15:0] sb [$];

  int          mcnt;
  int          midx;
  logic [31:0] msh;

  seg7_scan #(
    .REFRESH_DIV (RD),
    .BLANK_CYC   (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Reference model: predicts the outputs each edge will produce
  always @(posedge clk) begin
    logic [7:0]  ea;
    logic [6:0]  es;
    logic        ef;
    logic [31:0] up;
    logic        blank;
    if (rst) begin
      mcnt = 0;
      midx = 0;
      msh  = 0;
      ecnt = 0;
      sb.push_back({8'hFF, 7'h7F, 1'b0});
    end else begin
      ecnt++;
      up = msh;
      for (int k = 0; k < midx; k++) up = up / 16;
      blank = mcnt < BC;
`ifdef SEG7_LZ_BLANK_EN
      if (midx != 0 && up == 0) blank = 1'b1;
`endif
      ea = blank ? 8'hFF : (8'hFF ^ (8'h01 << midx));
      es = blank ? 7'h7F : glyph(up[3:0]);
      ef = (midx == 7) && (mcnt == RD - 1);
      sb.push_back({ea, es, ef});
      if (mcnt == RD - 1) begin
        mcnt = 0;
        if (midx == 7) begin
          midx = 0;
          msh  = data_in;
        end else begin
          midx++;
        end
      end else begin
        mcnt++;
      end
    end
  end

  always @(posedge rst) begin
    sb.delete();
    mcnt = 0;
    midx = 0;
    msh  = 0;
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_an", 32'(an), 32'(e[15:8]));
      chk("sb_seg", 32'(seg), 32'(e[7:1]));
      chk("sb_fd", 32'(frame_done), 32'(e[0]));
    end
  end

  task automatic wait_fd(input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (i >= 200) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic capture(input int d, output logic [6:0] s);
    int i;
    i = 0;
    @(negedge clk);
    while (an !== (8'hFF ^ (8'h01 << d)) && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (i >= 200) chk("digit_timeout", 32'(d), 32'hFFFF);
    s = seg;
  endtask

  initial begin
    logic [6:0] s;
    int         e0;
    int         bad;
    n_run   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    data_in = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_fd", 32'(frame_done), 32'h0);
    rst     = 1'b0;
    data_in = 32'h1234ABCD;
    @(negedge clk);
    chk("edge1_an", 32'(an), 32'hFF);
    @(negedge clk);
    chk("edge2_an", 32'(an), 32'hFF);
    @(negedge clk);
    chk("edge3_an", 32'(an), 32'hFE);
    chk("edge3_seg", 32'(seg), 32'h40);

    wait_fd("fd1");
    chk("fd1_edge", 32'(ecnt >= 8 * RD && ecnt <= 8 * RD + 1), 32'd1);
    e0 = ecnt;
    capture(0, s);
    chk("scan_d0", 32'(s), 32'b0100001);
    capture(3, s);
    data_in = 32'h55555555;
    capture(4, s);
    chk("hold_d4", 32'(s), 32'b0011001);
    capture(7, s);
    chk("hold_d7", 32'(s), 32'b1111001);
    wait_fd("fd2");
    chk("fd_period", 32'(ecnt - e0), 32'(8 * RD));
    capture(2, s);
    chk("five_d2", 32'(s), 32'b0010010);

    data_in = 32'h000000A5;
    wait_fd("fd3");
    capture(0, s);
    chk("lz_d0", 32'(s), 32'b0010010);
    capture(1, s);
    chk("lz_d1", 32'(s), 32'b0001000);
`ifdef SEG7_LZ_BLANK_EN
    bad = 0;
    for (int c = 0; c < 6 * RD; c++) begin
      @(negedge clk);
      if (an != 8'hFF && an != 8'hFD) bad++;
    end
    chk("lz_upper_dark", 32'(bad), 32'd0);
`else
    capture(7, s);
    chk("nolz_d7", 32'(s), 32'b1000000);
`endif

    data_in = 32'h0;
    wait_fd("fd4");
    bad = 0;
    for (int c = 0; c < 8 * RD; c++) begin
      @(negedge clk);
      if (an != 8'hFF && an != 8'hFE) bad++;
      if (an == 8'hFE && seg != 7'b1000000) bad++;
    end
`ifdef SEG7_LZ_BLANK_EN
    chk("zero_only_d0", 32'(bad), 32'd0);
`else
    capture(7, s);
    chk("zero_d7", 32'(s), 32'b1000000);
`endif

    data_in = 32'h1234ABCD;
    capture(5, s);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_an", 32'(an), 32'hFF);
    chk("mrst_seg", 32'(seg), 32'h7F);
    chk("mrst_fd", 32'(frame_done), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_restart", 32'(an), 32'hFE);
    wait_fd("fd5");
    chk("mrst_fd_edge", 32'(ecnt >= 8 * RD && ecnt <= 8 * RD + 1), 32'd1);
    capture(7, s);
    chk("mrst_d7", 32'(s), 32'b1111001);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
